// File: rtl/ras_ctrl_pkg.sv
// Shared configuration and type packages for the fetch-side RAS controller.
// MAX_IDS must match the checkpoint FIFO depth of the ras block.
package taiga_config;
  localparam int MAX_IDS = 8;
endpackage

package taiga_types;
  typedef enum logic [1:0] {NONE, PUSH, POP, POP_PUSH} ras_action_t;
  typedef enum logic {RUN, RECOVER} fsm_t;

  localparam logic [6:0] JAL_T    = 7'b1101111;
  localparam logic [6:0] JALR_T   = 7'b1100111;
  localparam logic [6:0] BRANCH_T = 7'b1100011;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction
endpackage

// File: rtl/ras_ctrl_if.sv
// Fetch-to-RAS control bus; ras_ctrl drives the strobes, the ras block returns the stack top.
interface ras_interface;
  logic        push;
  logic        pop;
  logic [31:0] new_addr;
  logic        branch_fetched;
  logic        branch_retired;
  logic [31:0] addr;

  modport master (output push, pop, new_addr, branch_fetched, branch_retired, input addr);
  modport slave  (input push, pop, new_addr, branch_fetched, branch_retired, output addr);
endinterface

// File: rtl/ras_ctrl_decode.sv
// Combinational call/return classifier for 32-bit fetch words.
// RAS_CTRL_COROUTINE_EN selects pop+push for link-to-different-link JALR.
module ras_decode
  import taiga_types::*;
(
  input  logic [31:0]  instr,
  output ras_action_t  action,
  output logic         is_branch
);
  logic [6:0] opcode;
  logic [4:0] rd, rs1;
  logic       rd_link, rs1_link;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign rd           = instr[11:7];
  assign rs1          = instr[19:15];
  assign rd_link      = is_link(rd);
  assign rs1_link     = is_link(rs1);
  assign unused_instr = ^{instr[31:20], instr[14:12]};

  always_comb begin
    action    = NONE;
    is_branch = 1'b0;
    case (opcode)
      JAL_T: begin
        is_branch = 1'b1;
        if (rd_link) action = PUSH;
      end
      JALR_T: begin
        is_branch = 1'b1;
        case ({rd_link, rs1_link})
          2'b01: action = POP;
          2'b10: action = PUSH;
          2'b11: begin
            if (rd == rs1) action = PUSH;
            else begin
`ifdef RAS_CTRL_COROUTINE_EN
              action = POP_PUSH;
`else
              action = PUSH;
`endif
            end
          end
          default: action = NONE;
        endcase
      end
      BRANCH_T: is_branch = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/ras_ctrl.sv
// Fetch-side RAS driver: decodes accepted words into push/pop strobes and
// bounds speculative branches in flight to the checkpoint FIFO depth.
module ras_ctrl
  import taiga_types::*;
  import taiga_config::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  input  logic [31:0]        fetch_pc,
  input  logic [31:0]        fetch_instr,
  input  logic               branch_retire,
  input  logic               gc_fetch_flush,
  output logic               ret_valid,
  output logic [31:0]        ret_target,
  output logic               inflight_err,
  ras_interface.master       ras
);
  localparam int CNT_W = $clog2(MAX_IDS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_IDS);

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q;
  ras_action_t      action;
  logic             is_branch;
  logic             blocked, full_stall, accept, retire_ok, inc, dec;

  ras_decode u_decode (
    .instr     (fetch_instr),
    .action    (action),
    .is_branch (is_branch)
  );

  // Flush cycle and the following recovery cycle both drop fetch and retires.
  always_comb begin
    state_d = state_q;
    blocked = 1'b0;
    case (state_q)
      RUN: begin
        if (gc_fetch_flush) begin
          state_d = RECOVER;
          blocked = 1'b1;
        end
      end
      RECOVER: begin
        state_d = RUN;
        blocked = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // A retire in the same cycle frees the slot the new branch needs.
  assign full_stall  = (count_q == MAX_CNT) && is_branch && !branch_retire;
  assign fetch_ready = rst_n && !blocked && !full_stall;
  assign accept      = fetch_valid && fetch_ready;
  assign retire_ok   = branch_retire && !blocked && (count_q != '0);
  assign inc         = accept && is_branch;
  assign dec         = retire_ok;

  assign ras.push           = accept && ((action == PUSH) || (action == POP_PUSH));
  assign ras.pop            = accept && ((action == POP)  || (action == POP_PUSH));
  assign ras.new_addr       = fetch_pc + 32'd4;
  assign ras.branch_fetched = inc;
  assign ras.branch_retired = retire_ok;
  assign ret_valid          = ras.pop;
  assign ret_target         = ras.addr;
  assign inflight_err       = err_q;

  always_comb begin
    count_d = count_q;
    if (blocked) count_d = '0;
    else begin
      case ({inc, dec})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (branch_retire && (count_q == '0)) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: call/return decode, in-flight limit, flush and underflow.
module tb_ras_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc, fetch_instr;
  logic        branch_retire, gc_fetch_flush;
  logic        ret_valid, inflight_err;
  logic [31:0] ret_target;
  int          nvec = 0;
  int          nerr = 0;

  localparam logic [31:0] JAL_X1     = 32'h0000_00EF;
  localparam logic [31:0] JAL_X0     = 32'h0000_006F;
  localparam logic [31:0] RET_X1     = 32'h0000_8067;
  localparam logic [31:0] JALR_X1_X5 = 32'h0002_80E7;
  localparam logic [31:0] JALR_X1_X1 = 32'h0000_80E7;
  localparam logic [31:0] BEQ        = 32'h0000_0063;
  localparam logic [31:0] NOP        = 32'h0000_0013;
`ifdef RAS_CTRL_COROUTINE_EN
  localparam logic [31:0] CO = 32'd1;
`else
  localparam logic [31:0] CO = 32'd0;
`endif

  always #5 clk = ~clk;

  ras_interface ras_if ();

  ras_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr),
    .branch_retire  (branch_retire),
    .gc_fetch_flush (gc_fetch_flush),
    .ret_valid      (ret_valid),
    .ret_target     (ret_target),
    .inflight_err   (inflight_err),
    .ras            (ras_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ret, input logic fl);
    fetch_valid    = v;
    fetch_pc       = pc;
    fetch_instr    = ins;
    branch_retire  = ret;
    gc_fetch_flush = fl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: strobes stay quiet even with a call presented
    ras_if.addr = 32'hDEAD_0000;
    drive(1'b1, 32'h100, JAL_X1, 1'b1, 1'b0);
    #3;
    chk("rst_push", 32'(ras_if.push), 0);
    chk("rst_bf", 32'(ras_if.branch_fetched), 0);
    chk("rst_br", 32'(ras_if.branch_retired), 0);
    chk("rst_retv", 32'(ret_valid), 0);
    chk("rst_err", 32'(inflight_err), 0);
    chk("rst_tgt", ret_target, 32'hDEAD_0000);
    step();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, NOP, 1'b0, 1'b0);
    @(negedge clk);
    chk("ready_after_rst", 32'(fetch_ready), 1);
    step();

    // jal x1 -> push, count 1
    drive(1'b1, 32'h100, JAL_X1, 1'b0, 1'b0);
    @(negedge clk);
    chk("jal_push", 32'(ras_if.push), 1);
    chk("jal_pop", 32'(ras_if.pop), 0);
    chk("jal_naddr", ras_if.new_addr, 32'h104);
    chk("jal_bf", 32'(ras_if.branch_fetched), 1);
    step();

    // return -> pop with target from stack top, count 2
    ras_if.addr = 32'h104;
    drive(1'b1, 32'h104, RET_X1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ret_pop", 32'(ras_if.pop), 1);
    chk("ret_push", 32'(ras_if.push), 0);
    chk("ret_valid", 32'(ret_valid), 1);
    chk("ret_target", ret_target, 32'h104);
    step();

    // coroutine jalr x1,0(x5), count 3
    drive(1'b1, 32'h200, JALR_X1_X5, 1'b0, 1'b0);
    @(negedge clk);
    chk("co_push", 32'(ras_if.push), 1);
    chk("co_pop", 32'(ras_if.pop), CO);
    chk("co_retv", 32'(ret_valid), CO);
    chk("co_naddr", ras_if.new_addr, 32'h204);
    step();

    // non-branch at wrap PC: no strobes, new_addr wraps
    drive(1'b1, 32'hFFFF_FFFC, NOP, 1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_naddr", ras_if.new_addr, 32'h0);
    chk("nop_bf", 32'(ras_if.branch_fetched), 0);
    chk("nop_push", 32'(ras_if.push), 0);
    step();

    // jalr x1,0(x1): push only, count 4
    drive(1'b1, 32'h300, JALR_X1_X1, 1'b0, 1'b0);
    @(negedge clk);
    chk("same_push", 32'(ras_if.push), 1);
    chk("same_pop", 32'(ras_if.pop), 0);
    step();

    // jal x0: branch without push, count 5
    drive(1'b1, 32'h400, JAL_X0, 1'b0, 1'b0);
    @(negedge clk);
    chk("j_push", 32'(ras_if.push), 0);
    chk("j_bf", 32'(ras_if.branch_fetched), 1);
    step();

    // Flush in cycle N with count 5
    drive(1'b1, 32'h500, JAL_X1, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_n_ready", 32'(fetch_ready), 0);
    chk("fl_n_push", 32'(ras_if.push), 0);
    chk("fl_n_bf", 32'(ras_if.branch_fetched), 0);
    chk("fl_n_br", 32'(ras_if.branch_retired), 0);
    step();
    drive(1'b1, 32'h500, JAL_X1, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_n1_ready", 32'(fetch_ready), 0);
    chk("fl_n1_push", 32'(ras_if.push), 0);
    step();
    @(negedge clk);
    chk("fl_n2_ready", 32'(fetch_ready), 1);
    chk("fl_n2_push", 32'(ras_if.push), 1);
    step();

    // Count is 1 after flush; seven more fill to 8
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h600 + 32'(i * 4), BEQ, 1'b0, 1'b0);
      @(negedge clk);
      chk("fill_ready", 32'(fetch_ready), 1);
      step();
    end
    @(negedge clk);
    chk("full_ready", 32'(fetch_ready), 0);
    chk("full_bf", 32'(ras_if.branch_fetched), 0);
    step();
    drive(1'b1, 32'h700, NOP, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_nop_ready", 32'(fetch_ready), 1);
    step();
    drive(1'b1, 32'h704, BEQ, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_ret_ready", 32'(fetch_ready), 1);
    chk("full_ret_bf", 32'(ras_if.branch_fetched), 1);
    chk("full_ret_br", 32'(ras_if.branch_retired), 1);
    step();
    drive(1'b1, 32'h708, BEQ, 1'b0, 1'b0);
    @(negedge clk);
    chk("still_full", 32'(fetch_ready), 0);
    step();

    // Drain exactly 8, then underflow
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, NOP, 1'b1, 1'b0);
      @(negedge clk);
      chk("drain_br", 32'(ras_if.branch_retired), 1);
      step();
    end
    @(negedge clk);
    chk("uf_br", 32'(ras_if.branch_retired), 0);
    chk("uf_err_pre", 32'(inflight_err), 0);
    step();
    drive(1'b0, 32'h0, NOP, 1'b0, 1'b0);
    @(negedge clk);
    chk("uf_err", 32'(inflight_err), 1);
    step();
    step();
    chk("uf_err_sticky", 32'(inflight_err), 1);

    drive(1'b1, 32'h100, JAL_X1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst2_err", 32'(inflight_err), 0);
    chk("rst2_push", 32'(ras_if.push), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
